// File: rtl/conv_mem_responder.sv
// conv_mem_responder: image/layer memories and ready/busy start handshake for the CONV accelerator.
// Optional CONV_MEM_CHECK_EN adds sticky err_flags[3:0] for illegal accesses.
module conv_mem_responder #(
  parameter int IMG_DEPTH  = 4096,
  parameter int L0_DEPTH   = 4096,
  parameter int L1_DEPTH   = 1024,
  parameter int HS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_img_we,
  input  logic [11:0] host_img_addr,
  input  logic [19:0] host_img_data,
  input  logic        host_start,
  input  logic [2:0]  host_rd_sel,
  input  logic [11:0] host_rd_addr,
  output logic [19:0] host_rd_data,
  output logic        ready,
  input  logic        busy,
  input  logic [11:0] iaddr,
  output logic [19:0] idata,
  input  logic        cwr,
  input  logic [11:0] caddr_wr,
  input  logic [19:0] cdata_wr,
  input  logic        crd,
  input  logic [11:0] caddr_rd,
  output logic [19:0] cdata_rd,
  input  logic [2:0]  csel,
  output logic        done,
  output logic        hs_timeout,
  output logic [12:0] l0_wr_cnt,
  output logic [10:0] l1_wr_cnt
`ifdef CONV_MEM_CHECK_EN
  ,
  output logic [3:0]  err_flags
`endif
);
  localparam int L1W = $clog2(L1_DEPTH);
  localparam int HSW = $clog2(HS_TIMEOUT);
  localparam logic [12:0] L1_LIM = 13'(L1_DEPTH);
  localparam logic [HSW-1:0] HS_LAST = HSW'(HS_TIMEOUT - 1);
  typedef enum logic [1:0] {S_IDLE, S_HS, S_RUN, S_DONE} state_t;
  state_t r_state;
  logic r_ready, r_done, r_hs_timeout;
  logic [12:0] r_l0_cnt;
  logic [10:0] r_l1_cnt;
  logic [HSW-1:0] r_hs_cnt;
  logic [19:0] r_img [IMG_DEPTH];
  logic [19:0] r_l0 [L0_DEPTH];
  logic [19:0] r_l1 [L1_DEPTH];
  logic w_idle, w_run, w_l0_we, w_l1_we, w_wr_l1_ok, w_rd_l1_ok, w_host_l1_ok;
  assign w_idle       = r_state == S_IDLE;
  assign w_run        = r_state == S_RUN;
  assign w_wr_l1_ok   = {1'b0, caddr_wr} < L1_LIM;
  assign w_rd_l1_ok   = {1'b0, caddr_rd} < L1_LIM;
  assign w_host_l1_ok = {1'b0, host_rd_addr} < L1_LIM;
  assign w_l0_we      = w_run && cwr && csel == 3'b001;
  assign w_l1_we      = w_run && cwr && csel == 3'b011 && w_wr_l1_ok;
  assign ready        = r_ready;
  assign done         = r_done;
  assign hs_timeout   = r_hs_timeout;
  assign l0_wr_cnt    = r_l0_cnt;
  assign l1_wr_cnt    = r_l1_cnt;
  assign idata        = r_img[iaddr];
  // Reads see the array before this edge's write, giving read-before-write on collisions.
  assign cdata_rd = !crd ? '0 :
                    csel == 3'b001 ? r_l0[caddr_rd] :
                    (csel == 3'b011 && w_rd_l1_ok) ? r_l1[caddr_rd[L1W-1:0]] : '0;
  assign host_rd_data = host_rd_sel == 3'b001 ? r_l0[host_rd_addr] :
                        (host_rd_sel == 3'b011 && w_host_l1_ok) ? r_l1[host_rd_addr[L1W-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_idle && host_img_we) r_img[host_img_addr] <= host_img_data;
      if (w_l0_we) r_l0[caddr_wr] <= cdata_wr;
      if (w_l1_we) r_l1[caddr_wr[L1W-1:0]] <= cdata_wr;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_done       <= 1'b0;
      r_hs_timeout <= 1'b0;
      r_l0_cnt     <= '0;
      r_l1_cnt     <= '0;
      r_hs_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (host_start) begin
          r_state      <= S_HS;
          r_ready      <= 1'b1;
          r_hs_timeout <= 1'b0;
          r_l0_cnt     <= '0;
          r_l1_cnt     <= '0;
          r_hs_cnt     <= '0;
        end
        S_HS: if (busy) begin
          r_state <= S_RUN;
          r_ready <= 1'b0;
        end else if (r_hs_cnt == HS_LAST) begin
          r_state      <= S_IDLE;
          r_ready      <= 1'b0;
          r_hs_timeout <= 1'b1;
        end else r_hs_cnt <= r_hs_cnt + 1'b1;
        S_RUN: begin
          if (w_l0_we) r_l0_cnt <= r_l0_cnt + 13'(r_l0_cnt != '1);
          if (w_l1_we) r_l1_cnt <= r_l1_cnt + 11'(r_l1_cnt != '1);
          if (!busy) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef CONV_MEM_CHECK_EN
  logic [3:0] r_err;
  logic w_bad_sel, w_bad_l1;
  assign w_bad_sel = (cwr || crd) && csel != 3'b001 && csel != 3'b011;
  assign w_bad_l1  = csel == 3'b011 && ((cwr && !w_wr_l1_ok) || (crd && !w_rd_l1_ok));
  assign err_flags = r_err;
  always_ff @(posedge clk) begin
    if (!reset || (w_idle && host_start)) r_err <= '0;
    else r_err <= r_err | {host_img_we && !w_idle, (cwr || crd) && !w_run, w_bad_l1, w_bad_sel};
  end
`endif
endmodule
